// File: rtl/qpsk_tx_ctrl_if.sv
// qpsk_tx_ctrl_if: host-control / filter-side bundle of the QPSK transmit sequencer.
//   i_start, i_stop : level-sampled start/stop requests from the host
//   i_burst_len     : symbols per burst, 0 = unlimited (only with QPSK_TX_CTRL_BURST_EN)
//   o_enable        : one-clock sample strobe to the I/Q filters
//   o_phase         : phase of the current symbol, 0..3
//   o_bit_i/o_bit_q : PRBS9 symbol bits for the I and Q channels
//   o_busy          : sequencer not idle
//   o_sym_cnt       : symbols completed since the last start, saturating
// Modports: master = host/filter side, slave = sequencer.
// Build option: QPSK_TX_CTRL_BURST_EN adds i_burst_len.
interface qpsk_tx_ctrl_if;
  logic        i_start;
  logic        i_stop;
`ifdef QPSK_TX_CTRL_BURST_EN
  logic [15:0] i_burst_len;
`endif
  logic        o_enable;
  logic [1:0]  o_phase;
  logic        o_bit_i;
  logic        o_bit_q;
  logic        o_busy;
  logic [15:0] o_sym_cnt;

  modport master (
`ifdef QPSK_TX_CTRL_BURST_EN
    output i_burst_len,
`endif
    output i_start, i_stop,
    input  o_enable, o_phase, o_bit_i, o_bit_q, o_busy, o_sym_cnt
  );

  modport slave (
`ifdef QPSK_TX_CTRL_BURST_EN
    input  i_burst_len,
`endif
    input  i_start, i_stop,
    output o_enable, o_phase, o_bit_i, o_bit_q, o_busy, o_sym_cnt
  );
endinterface

// File: rtl/qpsk_tx_ctrl.sv
// qpsk_tx_ctrl: QPSK transmit sequencer. Generates the sample-rate enable,
// the 2-bit symbol phase and one PRBS9 bit per channel (held for four
// enables), with a start/stop/drain FSM so transmission ends on a symbol
// boundary.
// Parameters: CLK_DIV (clocks per enable, 1..255), SEED_I / SEED_Q (nonzero PRBS9 seeds).
// Ports: clk, rst (synchronous, active-high), bus (qpsk_tx_ctrl_if.slave).
// Build option: QPSK_TX_CTRL_BURST_EN enables burst-length termination.
module qpsk_tx_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [8:0]  SEED_I  = 9'h1AA,
  parameter logic [8:0]  SEED_Q  = 9'h1FE
) (
  input  logic          clk,
  input  logic          rst,
  qpsk_tx_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               en_q, en_d;
  logic [1:0]         phase_q, phase_d;
  logic [8:0]         prbs_i_q, prbs_i_d;
  logic [8:0]         prbs_q_q, prbs_q_d;
  logic               bit_i_q, bit_i_d;
  logic               bit_q_q, bit_q_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
`ifdef QPSK_TX_CTRL_BURST_EN
  logic [CNT_W-1:0]   burst_q, burst_d;
`endif

  logic               div_wrap;
  logic               boundary;
  logic [CNT_W-1:0]   sym_inc;
  logic [8:0]         step_i;
  logic [8:0]         step_q;
  logic               burst_done;

  // Enable is registered from the wrap decode, so phase/bits advance on the
  // edge that closes the enable cycle and are stable while the filters sample.
  assign div_wrap = (div_q == DIV_LAST);
  assign boundary = en_q && (phase_q == 2'd3);
  assign sym_inc  = (sym_cnt_q == {CNT_W{1'b1}}) ? sym_cnt_q : sym_cnt_q + CNT_W'(1);
  assign step_i   = {prbs_i_q[7:0], prbs_i_q[8] ^ prbs_i_q[4]};
  assign step_q   = {prbs_q_q[7:0], prbs_q_q[8] ^ prbs_q_q[4]};

  // Burst ends when the count about to be committed reaches the latched length.
`ifdef QPSK_TX_CTRL_BURST_EN
  assign burst_done = (burst_q != '0) && (sym_inc == burst_q);
`else
  assign burst_done = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      en_q      <= 1'b0;
      phase_q   <= '0;
      prbs_i_q  <= SEED_I;
      prbs_q_q  <= SEED_Q;
      bit_i_q   <= 1'b0;
      bit_q_q   <= 1'b0;
      busy_q    <= 1'b0;
      sym_cnt_q <= '0;
`ifdef QPSK_TX_CTRL_BURST_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      en_q      <= en_d;
      phase_q   <= phase_d;
      prbs_i_q  <= prbs_i_d;
      prbs_q_q  <= prbs_q_d;
      bit_i_q   <= bit_i_d;
      bit_q_q   <= bit_q_d;
      busy_q    <= busy_d;
      sym_cnt_q <= sym_cnt_d;
`ifdef QPSK_TX_CTRL_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    en_d      = 1'b0;
    phase_d   = phase_q;
    prbs_i_d  = prbs_i_q;
    prbs_q_d  = prbs_q_q;
    bit_i_d   = bit_i_q;
    bit_q_d   = bit_q_q;
    sym_cnt_d = sym_cnt_q;
`ifdef QPSK_TX_CTRL_BURST_EN
    burst_d   = burst_q;
`endif

    case (state_q)
      IDLE: begin
        div_d   = '0;
        phase_d = '0;
        // Start wins over stop; stop has no meaning here.
        if (bus.i_start) begin
          state_d   = RUN;
          prbs_i_d  = SEED_I;
          prbs_q_d  = SEED_Q;
          bit_i_d   = SEED_I[8];
          bit_q_d   = SEED_Q[8];
          sym_cnt_d = '0;
`ifdef QPSK_TX_CTRL_BURST_EN
          burst_d   = bus.i_burst_len;
`endif
        end
      end

      RUN, DRAIN: begin
        en_d  = div_wrap;
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (en_q) begin
          phase_d = phase_q + 2'd1;
        end
        if ((state_q == RUN) && bus.i_stop) begin
          state_d = DRAIN;
        end
        // Symbol boundary: count it, then either finish or step the PRBS.
        if (boundary) begin
          sym_cnt_d = sym_inc;
          if ((state_q == DRAIN) || burst_done) begin
            state_d = IDLE;
            en_d    = 1'b0;
            div_d   = '0;
            phase_d = '0;
          end else begin
            prbs_i_d = step_i;
            prbs_q_d = step_q;
            bit_i_d  = step_i[8];
            bit_q_d  = step_q[8];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.o_enable  = en_q;
  assign bus.o_phase   = phase_q;
  assign bus.o_bit_i   = bit_i_q;
  assign bus.o_bit_q   = bit_q_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_sym_cnt = sym_cnt_q;

endmodule

// File: doc/qpsk_tx_ctrl.md
# qpsk_tx_ctrl

Sequencer for the QPSK transmit path. It generates the sample-rate enable strobe and the phase count that the I and Q pulse-shaping filters consume. It produces one PRBS9 symbol bit per channel, held for four enables, and runs a start/stop/drain state machine so symbols always end on a boundary. It sits between the host control registers and the two per-channel polyphase transmit filters.

## Interface
- CLK_DIV, 4: clocks per sample enable; legal range 1..255.
- SEED_I, 9'h1AA: PRBS9 seed for the I channel; must be nonzero.
- SEED_Q, 9'h1FE: PRBS9 seed for the Q channel; must be nonzero.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  start request, level-sampled.
- i_stop  in  1  stop request, level-sampled.
- i_burst_len  in  16  symbols per burst; 0 means unlimited. Present only with QPSK_TX_CTRL_BURST_EN.
- o_enable  out  1  one-clock sample strobe to both filters.
- o_phase  out  2  phase of the current symbol, 0..3.
- o_bit_i  out  1  I-channel symbol bit.
- o_bit_q  out  1  Q-channel symbol bit.
- o_busy  out  1  high whenever state != IDLE.
- o_sym_cnt  out  16  symbols completed since the last start; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - div counter = 0, phase = 0, o_enable = 0.
  - i_start = 1: next state RUN. In the same edge, reload both PRBS registers with their seeds, clear o_sym_cnt, and drive the bit outputs with the seed MSBs.
  - i_stop is ignored in IDLE. If i_start and i_stop are both high, start wins.
- RUN:
  - The div counter counts 0..CLK_DIV-1 and wraps.
  - o_enable = 1 for exactly the cycle in which the counter equals CLK_DIV-1. With CLK_DIV = 1, o_enable is continuously high.
  - Each enable advances o_phase modulo 4.
  - An enable with o_phase = 3 is the symbol boundary. At the boundary:
    - Both PRBS registers step: new = {r[7:0], r[8]^r[4]}. The output bit is the MSB of the new register.
    - o_sym_cnt increments.
  - i_stop = 1 in RUN: next state DRAIN. i_start is ignored in RUN.
- DRAIN:
  - Identical to RUN until the next symbol boundary.
  - At that boundary, go to IDLE. The PRBS does not step; the final o_sym_cnt increment does occur.
  - i_start and i_stop are ignored in DRAIN.
- o_bit_i and o_bit_q change only at a symbol boundary or at start. Each bit is therefore presented for exactly four consecutive enables, phases 0..3.

## Timing
- Reset values: state IDLE; o_enable 0, o_phase 0, o_bit_i 0, o_bit_q 0, o_busy 0, o_sym_cnt 0. PRBS registers = seeds.
- All outputs are registered. There is no combinational path from input to output.
- Start latency:
  - o_busy rises one cycle after i_start is sampled.
  - The first o_enable appears CLK_DIV cycles after o_busy rises.
- Bit update timing:
  - o_bit_* and o_phase update on the same edge that ends the enable cycle.
  - The filter therefore samples a stable bit/phase at every enable.
- Stop latency: o_busy falls on the edge after the first symbol-boundary enable following i_stop. Worst case is 4*CLK_DIV + 1 cycles.
- Reset mid-RUN or mid-DRAIN: return to IDLE immediately. Any partial symbol is discarded and the PRBS registers are reloaded.

## Configuration
- QPSK_TX_CTRL_BURST_EN defined:
  - The i_burst_len port exists.
  - In RUN, when o_sym_cnt reaches a nonzero i_burst_len at a boundary, go directly to IDLE, as if a drain had just completed.
  - i_burst_len is sampled on start and held internally.
- QPSK_TX_CTRL_BURST_EN undefined: the port is absent, and only i_stop ends transmission.

## Test plan
- Reset release, then idle for 20 cycles: all outputs remain 0; o_enable never pulses.
- CLK_DIV=4, pulse i_start for one cycle:
  - o_enable pulses every 4 clocks.
  - o_phase runs 0,1,2,3,0.
  - The first three I bits are 1,1,0 (register 1AA→155→0AA).
  - The first two Q bits are 1,1.
- Assert i_stop at o_phase = 1 of symbol 5:
  - Exactly 2 more enables occur (phases 2,3).
  - o_busy falls one cycle later.
  - o_sym_cnt = 5.
- i_start and i_stop high together in IDLE: the block enters RUN. Holding both high in RUN moves it to DRAIN, then IDLE. It restarts only after i_start is re-sampled in IDLE.
- CLK_DIV=1: o_enable is continuously high in RUN, and o_bit_i changes every 4 clocks.
- BURST_EN with i_burst_len=3: exactly 12 enables occur, o_sym_cnt = 3, then the block returns to IDLE. With i_burst_len=0, it runs until i_stop.
